// File: rtl/atto_link_pkg.sv
// Shared definitions for the token-link scheduler: FSM states, idle link levels
// and a width helper.
package atto_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_WAIT_ACK
  } link_state_e;

  localparam logic LINK_P_IDLE = 1'b1;
  localparam logic LINK_N_IDLE = 1'b0;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while (((32'd1 << w) < n) && (w < 31)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority search: first set request at or above rr_ptr, wrapping at N_REQ.
module rr_priority_picker
  import atto_link_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    index,
  output logic             any
);

  always_comb begin : search
    logic [IW:0] j;
    pick  = '0;
    index = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // rr_ptr < N_REQ, so a single subtraction is enough to wrap
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
      if (!any && req[j[IW-1:0]]) begin
        any              = 1'b1;
        pick[j[IW-1:0]]  = 1'b1;
        index            = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/output_link_scheduler.sv
// Round-robin, packet-granular scheduler for a shared outbound two-wire token link;
// one flit per token, next flit waits for the return token on ack_p/ack_n.
module output_link_scheduler
  import atto_link_pkg::*;
#(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned MAX_FLITS   = 8,
  parameter  int unsigned ACK_TIMEOUT = 255,
  localparam int unsigned SW          = clog2(N_REQ)
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] tail,
  output logic [N_REQ-1:0] gnt,
  output logic [SW-1:0]    sel,
  output logic             xfer,
  output logic             link_p,
  output logic             link_n,
  input  logic             ack_p,
  input  logic             ack_n,
  output logic             proto_err,
  output logic             tmo_err
);

  localparam int unsigned     FW        = clog2(MAX_FLITS + 1);
  localparam int unsigned     TW        = clog2(ACK_TIMEOUT + 1);
  localparam logic [FW-1:0]   FLIT_LAST = FW'(MAX_FLITS);
  localparam logic [TW-1:0]   TMO_LIMIT = TW'(ACK_TIMEOUT);
  localparam logic [SW-1:0]   SEL_TOP   = SW'(N_REQ - 1);

  link_state_e      state_q, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [SW-1:0]    sel_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [FW-1:0]    flit_cnt_q, flit_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             last_q, last_d;
  logic             xfer_d;
  logic             link_p_d, link_n_d;
  logic             proto_err_d, tmo_err_d;
  logic             ackp_q, ackn_q;
  logic             ack_hit;

  logic [N_REQ-1:0] pick;
  logic [SW-1:0]    pick_idx;
  logic             pick_any;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Only a change on both wires is a token; a lone wire change is left pending.
  assign ack_hit = (ack_p ^ ackp_q) & (ack_n ^ ackn_q);

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q    <= ST_IDLE;
      gnt        <= '0;
      sel        <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      last_q     <= 1'b0;
      xfer       <= 1'b0;
      link_p     <= LINK_P_IDLE;
      link_n     <= LINK_N_IDLE;
      ackp_q     <= LINK_P_IDLE;
      ackn_q     <= LINK_N_IDLE;
      proto_err  <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt        <= gnt_d;
      sel        <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      flit_cnt_q <= flit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      last_q     <= last_d;
      xfer       <= xfer_d;
      link_p     <= link_p_d;
      link_n     <= link_n_d;
      ackp_q     <= ackp_q ^ ack_hit;
      ackn_q     <= ackn_q ^ ack_hit;
      proto_err  <= proto_err_d;
      tmo_err    <= tmo_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    sel_d       = sel;
    rr_ptr_d    = rr_ptr_q;
    flit_cnt_d  = flit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    last_d      = last_q;
    xfer_d      = 1'b0;
    link_p_d    = link_p;
    link_n_d    = link_n;
    tmo_err_d   = tmo_err;
    proto_err_d = proto_err | (ack_hit & (state_q != ST_WAIT_ACK));

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d      = pick;
          sel_d      = pick_idx;
          flit_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[sel]) begin
          link_p_d = ~link_p;
          link_n_d = ~link_n;
          xfer_d   = 1'b1;
          last_d   = tail[sel] | (flit_cnt_q + FW'(1) == FLIT_LAST);
          state_d  = ST_SEND;
        end else if (flit_cnt_q == '0) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        flit_cnt_d = flit_cnt_q + FW'(1);
        tmo_cnt_d  = '0;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_hit) begin
          if (last_q) begin
            gnt_d    = '0;
            rr_ptr_d = (sel == SEL_TOP) ? '0 : sel + SW'(1);
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_GRANT;
          end
        end
        // Counter saturates at the limit; the error flag is raised on the reaching edge
        if ((ACK_TIMEOUT != 0) && (tmo_cnt_q != TMO_LIMIT)) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_q + TW'(1) == TMO_LIMIT) tmo_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_link_scheduler.sv
// Self-checking bench for output_link_scheduler: vector table, directed corner
// sequences and randomized traffic against a flag-based behavioural model.
module tb_output_link_scheduler;

  localparam int unsigned NR  = 4;
  localparam int unsigned MF  = 3;
  localparam int unsigned TMO = 4;

  logic          clka = 1'b0;
  logic          rsta;
  logic [NR-1:0] req, tail, gnt;
  logic [1:0]    sel;
  logic          xfer, link_p, link_n, ack_p, ack_n, proto_err, tmo_err;

  output_link_scheduler #(.N_REQ(NR), .MAX_FLITS(MF), .ACK_TIMEOUT(TMO)) dut (
    .clka(clka), .rsta(rsta), .req(req), .tail(tail), .gnt(gnt), .sel(sel),
    .xfer(xfer), .link_p(link_p), .link_n(link_n), .ack_p(ack_p), .ack_n(ack_n),
    .proto_err(proto_err), .tmo_err(tmo_err)
  );

  always #5 clka = ~clka;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_busy, m_launch, m_waiting, m_last;
  logic       m_lp, m_ln, m_ap, m_an, m_perr, m_terr;
  logic [1:0] m_sel;
  int         m_sent, m_ptr, m_wc;

  function automatic void model_reset();
    m_busy = 0; m_launch = 0; m_waiting = 0; m_last = 0;
    m_lp = 1; m_ln = 0; m_ap = 1; m_an = 0; m_perr = 0; m_terr = 0;
    m_sel = 0; m_sent = 0; m_ptr = 0; m_wc = 0;
  endfunction

  function automatic void model_step();
    logic hit;
    logic found;
    int   idx;
    hit = (ack_p != m_ap) && (ack_n != m_an);
    if (hit) begin
      m_ap = ack_p;
      m_an = ack_n;
      if (!m_waiting) m_perr = 1;
    end
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < int'(NR); k++) begin
        idx = (m_ptr + k) % int'(NR);
        if (!found && req[idx]) begin
          found = 1; m_busy = 1; m_sel = 2'(idx); m_sent = 0;
        end
      end
    end else if (m_launch) begin
      m_launch = 0; m_waiting = 1; m_sent++; m_wc = 0;
    end else if (m_waiting) begin
      if (hit) begin
        m_waiting = 0;
        if (m_last) begin
          m_busy = 0;
          m_ptr  = (int'(m_sel) + 1) % int'(NR);
        end
      end
      if (TMO != 0 && m_wc < int'(TMO)) begin
        m_wc++;
        if (m_wc == int'(TMO)) m_terr = 1;
      end
    end else begin
      if (req[m_sel]) begin
        m_launch = 1; m_lp = !m_lp; m_ln = !m_ln;
        m_last = tail[m_sel] || (m_sent + 1 == int'(MF));
      end else if (m_sent == 0) begin
        m_busy = 0;
      end
    end
  endfunction

  function automatic logic [10:0] model_vec();
    logic [3:0] g;
    g = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    return {g, m_sel, m_launch, m_lp, m_ln, m_perr, m_terr};
  endfunction

  // ---------------- stimulus helpers ----------------
  logic auto_ack = 0;
  logic rand_dly = 0;
  int   ack_dly  = 0;

  task automatic step();
    if (auto_ack && m_waiting && m_wc == ack_dly) begin
      ack_p = ~ack_p;
      ack_n = ~ack_n;
    end
    model_step();
    @(posedge clka);
    #1;
    if (rand_dly && m_launch) ack_dly = $urandom_range(0, 2);
    check("model", 32'({gnt, sel, xfer, link_p, link_n, proto_err, tmo_err}), 32'(model_vec()));
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] tail;
    logic       tgl;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       xfer;
    logic       lp;
    logic       ln;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic [3:0] t, input logic g_tgl,
                              input logic [3:0] g, input logic [1:0] s, input logic x,
                              input logic lp, input logic ln);
    vec_t v;
    v.req = r; v.tail = t; v.tgl = g_tgl; v.gnt = g; v.sel = s; v.xfer = x; v.lp = lp; v.ln = ln;
    vecs.push_back(v);
  endfunction

  initial begin
    int   order[6];
    logic lp, ln;
    int   n_x, n_t;
    logic prev;

    rsta = 1; req = 0; tail = 0; ack_p = 1; ack_n = 0;
    model_reset();
    #1 rsta = 0;
    #1 check("reset state", 32'({gnt, sel, xfer, link_p, link_n, proto_err, tmo_err}),
             32'(11'b0000_00_0_10_00));
    #19 rsta = 1;

    // Single flit to requester 2, then round robin 3,0,1,2,3,0 with one flit each
    add(4'b0100, 4'b0100, 0, 4'b0100, 2'd2, 0, 1, 0);
    add(4'b0100, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, 1);
    add(4'b0100, 4'b0100, 0, 4'b0100, 2'd2, 0, 0, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 2'd2, 0, 0, 1);
    order = '{3, 0, 1, 2, 3, 0};
    lp = 0; ln = 1;
    foreach (order[p]) begin
      add(4'b1111, 4'b1111, 0, 4'b0001 << order[p], 2'(order[p]), 0, lp, ln);
      lp = ~lp; ln = ~ln;
      add(4'b1111, 4'b1111, 0, 4'b0001 << order[p], 2'(order[p]), 1, lp, ln);
      add(4'b1111, 4'b1111, 0, 4'b0001 << order[p], 2'(order[p]), 0, lp, ln);
      add(4'b1111, 4'b1111, 1, 4'b0000,             2'(order[p]), 0, lp, ln);
    end
    foreach (vecs[i]) begin
      req = vecs[i].req;
      tail = vecs[i].tail;
      if (vecs[i].tgl) begin ack_p = ~ack_p; ack_n = ~ack_n; end
      step();
      check($sformatf("vec%0d", i), 32'({gnt, sel, xfer, link_p, link_n}),
            32'({vecs[i].gnt, vecs[i].sel, vecs[i].xfer, vecs[i].lp, vecs[i].ln}));
    end

    // Forced tail at MAX_FLITS, prompt acks
    auto_ack = 1; ack_dly = 0;
    req = 4'b0010; tail = 4'b0000;
    n_x = 0; n_t = 0; prev = link_p;
    for (int c = 0; c < 10; c++) begin
      step();
      if (xfer) n_x++;
      if (link_p != prev) n_t++;
      prev = link_p;
    end
    check("forced tail xfer count", 32'(n_x), 32'd3);
    check("forced tail toggles", 32'(n_t), 32'd3);
    check("forced tail release", 32'(gnt), 32'd0);
    req = 4'b0110;
    step();
    check("next after forced tail", 32'(gnt), 32'b0100);
    req = 4'b0000;
    step();
    check("grant withdrawn", 32'({gnt, xfer}), 32'd0);

    // Mid-packet stall
    req = 4'b0001; tail = 4'b0000;
    repeat (4) step();
    check("stall start gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall gnt held", 32'(gnt), 32'b0001);
      check("stall no xfer", 32'(xfer), 32'd0);
    end
    req = 4'b0001; tail = 4'b0001;
    step();
    check("stall resume xfer", 32'(xfer), 32'd1);
    repeat (2) step();
    check("stall packet done", 32'(gnt), 32'd0);
    req = 0; tail = 0;

    // Ack errors
    auto_ack = 0;
    req = 4'b0010; tail = 4'b0010;
    repeat (3) step();
    req = 0; tail = 0;
    ack_p = ~ack_p;
    step();
    check("single wire ignored", 32'({gnt, proto_err}), 32'({4'b0010, 1'b0}));
    ack_p = ~ack_p;
    step();
    check("single wire restored", 32'(gnt), 32'b0010);
    ack_p = ~ack_p; ack_n = ~ack_n;
    step();
    check("ack after glitch", 32'({gnt, proto_err, tmo_err}), 32'd0);
    ack_p = ~ack_p; ack_n = ~ack_n;
    step();
    check("proto_err in idle", 32'(proto_err), 32'd1);
    req = 4'b0100; tail = 4'b0100;
    repeat (3) step();
    req = 0; tail = 0;
    repeat (3) step();
    check("no timeout yet", 32'(tmo_err), 32'd0);
    step();
    check("timeout flagged", 32'({gnt, tmo_err}), 32'({4'b0100, 1'b1}));

    // Asynchronous reset during WAIT_ACK
    #2 rsta = 0; ack_p = 1; ack_n = 0;
    #1 check("async reset", 32'({gnt, sel, xfer, link_p, link_n, proto_err, tmo_err}),
             32'(11'b0000_00_0_10_00));
    model_reset();
    @(posedge clka);
    #1 check("reset held", 32'({gnt, xfer, link_p, link_n, proto_err, tmo_err}),
             32'(9'b0000_0_10_00));
    @(negedge clka) rsta = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle after reset", 32'({gnt, xfer, link_p, link_n}), 32'(7'b0000_0_10));
    end
    req = 4'b1000; tail = 4'b1000;
    step();
    check("grant after reset", 32'(gnt), 32'b1000);

    // Randomized traffic against the model
    auto_ack = 1; rand_dly = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req  = 4'($urandom_range(0, 15));
        tail = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
